// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: size codes, FSM
// states, read-latency bounds and the load-result formatter.
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_WORD    = 2'b00;
    localparam logic [1:0] SZ_BYTE_U  = 2'b01;
    localparam logic [1:0] SZ_BYTE_S  = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int LAT_CNT_W  = $clog2(RD_LAT_MAX + 1);

    // Assemble a load result from the two byte lanes according to size.
    function automatic logic [15:0] format_load(input logic [1:0] size,
                                                input logic [7:0] b1,
                                                input logic [7:0] b0);
        logic [15:0] res;
        case (size)
            SZ_WORD:   res = {b1, b0};
            SZ_BYTE_U: res = {8'h00, b0};
            SZ_BYTE_S: res = {{8{b0[7]}}, b0};
            default:   res = 16'h0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter timing the memory read latency. done is high during
// the last cycle of the programmed interval.
module mem_lat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_reg;

    // Load on entry to the wait interval, then count down to zero and park.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - W'(1);
        end
    end

    assign done = (cnt_reg == W'(1));

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the byte-wide data-memory interface. Splits 16-bit
// accesses into two little-endian byte transactions, waits out the read
// latency, formats the result and returns a one-cycle response. Every output
// is registered from the next-state values, so req_* never reaches mem_*
// combinationally.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              resp_valid,
    output logic [15:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    // Out-of-range latencies are clamped into the supported window.
    localparam int RL_EFF = (RD_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                            (RD_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : RD_LATENCY;

    state_t            state_reg, state_next;
    logic              bidx_reg, bidx_next;
    logic              write_reg;
    logic [1:0]        size_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [15:0]       wdata_reg;

    logic              accept, more_bytes, lat_load, lat_done;
    logic              write_cur;
    logic [1:0]        size_cur;
    logic [ADDR_W-1:0] addr_cur;
    logic [15:0]       wdata_cur;
    logic [15:0]       lane_next;

    logic              req_ready_reg, busy_reg, resp_valid_reg, resp_err_reg;
    logic              mem_wr_en_reg, mem_rd_en_reg;
    logic [15:0]       resp_rdata_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [7:0]        mem_wdata_reg;

    logic              req_ready_next, busy_next, resp_valid_next, resp_err_next;
    logic              mem_wr_en_next, mem_rd_en_next;
    logic [15:0]       resp_rdata_next;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [7:0]        mem_wdata_next;

    assign accept     = (state_reg == ST_IDLE) && req_valid;
    assign more_bytes = (size_reg == SZ_WORD) && !bidx_reg;

    // The request fields seen by the output registers: fresh on the accept
    // cycle, latched copies afterwards.
    assign write_cur = accept ? req_write : write_reg;
    assign size_cur  = accept ? req_size  : size_reg;
    assign addr_cur  = accept ? req_addr  : addr_reg;
    assign wdata_cur = accept ? req_wdata : wdata_reg;

    mem_lat_counter #(
        .W(LAT_CNT_W)
    ) u_lat (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lat_load),
        .load_val (LAT_CNT_W'(RL_EFF)),
        .done     (lat_done)
    );

    // Byte lanes: cleared on accept, lane bidx captured on the last WAIT cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [7:0] byte_reg;
        logic       cap;

        assign cap = (state_reg == ST_WAIT) && lat_done && (bidx_reg == 1'(gi));
        assign lane_next[gi*8 +: 8] = accept ? 8'h00 : (cap ? mem_rdata : byte_reg);

        // Hold the captured byte for the formatter.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                byte_reg <= 8'h00;
            end else begin
                byte_reg <= lane_next[gi*8 +: 8];
            end
        end
    end

    // Latch the request on acceptance; req_* are ignored until back in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_reg <= 1'b0;
            size_reg  <= SZ_WORD;
            addr_reg  <= '0;
            wdata_reg <= 16'h0000;
        end else if (accept) begin
            write_reg <= req_write;
            size_reg  <= req_size;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
        end
    end

    // Next-state logic and the next values of every registered output.
    always_comb begin
        state_next = state_reg;
        bidx_next  = bidx_reg;
        lat_load   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    bidx_next  = 1'b0;
                    state_next = (req_size == SZ_ILLEGAL) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (write_reg) begin
                    if (more_bytes) begin
                        bidx_next = 1'b1;
                    end else begin
                        state_next = ST_RESP;
                    end
                end else begin
                    lat_load   = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_done) begin
                    if (more_bytes) begin
                        bidx_next  = 1'b1;
                        state_next = ST_ISSUE;
                    end else begin
                        state_next = ST_RESP;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        req_ready_next  = (state_next == ST_IDLE);
        busy_next       = (state_next != ST_IDLE);
        mem_wr_en_next  = (state_next == ST_ISSUE) && write_cur;
        mem_rd_en_next  = (state_next == ST_ISSUE) && !write_cur;
        mem_addr_next   = (state_next == ST_ISSUE) ? addr_cur + ADDR_W'(bidx_next) : '0;
        mem_wdata_next  = 8'h00;
        if (mem_wr_en_next) begin
            mem_wdata_next = bidx_next ? wdata_cur[15:8] : wdata_cur[7:0];
        end
        resp_valid_next = (state_next == ST_RESP);
        resp_err_next   = resp_valid_next && (size_cur == SZ_ILLEGAL);
        resp_rdata_next = 16'h0000;
        if (resp_valid_next && !write_cur) begin
            resp_rdata_next = format_load(size_cur, lane_next[15:8], lane_next[7:0]);
        end
    end

    // State and output registers; reset drops every strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            bidx_reg       <= 1'b0;
            req_ready_reg  <= 1'b1;
            busy_reg       <= 1'b0;
            mem_wr_en_reg  <= 1'b0;
            mem_rd_en_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= 8'h00;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= 16'h0000;
        end else begin
            state_reg      <= state_next;
            bidx_reg       <= bidx_next;
            req_ready_reg  <= req_ready_next;
            busy_reg       <= busy_next;
            mem_wr_en_reg  <= mem_wr_en_next;
            mem_rd_en_reg  <= mem_rd_en_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            resp_valid_reg <= resp_valid_next;
            resp_err_reg   <= resp_err_next;
            resp_rdata_reg <= resp_rdata_next;
        end
    end

    assign req_ready  = req_ready_reg;
    assign busy       = busy_reg;
    assign mem_wr_en  = mem_wr_en_reg;
    assign mem_rd_en  = mem_rd_en_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_rdata = resp_rdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (read latency 1 and 3), each with
// its own byte memory, driven by a directed vector table, hand-written reset
// and back-to-back sequences, and random requests checked against a
// byte-array reference model.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]       req_valid, req_write, req_ready, resp_valid, resp_err, busy;
    logic [1:0]       mem_wr_en, mem_rd_en;
    logic [1:0][1:0]  req_size;
    logic [1:0][15:0] req_addr, req_wdata, resp_rdata, mem_addr;
    logic [1:0][7:0]  mem_wdata, mem_rdata;

    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = 16'h0;
    logic [7:0]  pl_data = 8'h0;

    logic [7:0] ref_mem [2][65536];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int RL = (gi == 0) ? 1 : 3;
        logic [7:0] mem [65536];
        logic [7:0] pipe [4];

        mem_access_unit #(.ADDR_W(16), .RD_LATENCY(RL)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid[gi]),
            .req_ready  (req_ready[gi]),
            .req_write  (req_write[gi]),
            .req_size   (req_size[gi]),
            .req_addr   (req_addr[gi]),
            .req_wdata  (req_wdata[gi]),
            .resp_valid (resp_valid[gi]),
            .resp_rdata (resp_rdata[gi]),
            .resp_err   (resp_err[gi]),
            .busy       (busy[gi]),
            .mem_wr_en  (mem_wr_en[gi]),
            .mem_rd_en  (mem_rd_en[gi]),
            .mem_addr   (mem_addr[gi]),
            .mem_wdata  (mem_wdata[gi]),
            .mem_rdata  (mem_rdata[gi])
        );

        // Byte memory: data appears RL cycles after the read strobe; junk otherwise.
        always @(posedge clk) begin
            if (pl_en) mem[pl_addr] <= pl_data;
            else if (mem_wr_en[gi]) mem[mem_addr[gi]] <= mem_wdata[gi];
            pipe[0] <= mem_rd_en[gi] ? mem[mem_addr[gi]] : 8'h5A;
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata[gi] = pipe[RL-1];
    end

    typedef struct {
        int          inst;
        logic        wr;
        logic [1:0]  sz;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(int inst, logic wr, logic [1:0] sz, logic [15:0] addr,
                                logic [15:0] wdata, logic [15:0] exp_rd, logic exp_err,
                                string name);
        vec_t v;
        v.inst = inst; v.wr = wr; v.sz = sz; v.addr = addr; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.name = name;
        return v;
    endfunction

    function automatic int rl_of(int inst);
        return (inst == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] dev_mem(int inst, logic [15:0] a);
        return (inst == 0) ? g_dut[0].mem[a] : g_dut[1].mem[a];
    endfunction

    // Response latency in cycles after the accept cycle.
    function automatic int model_lat(logic wr, logic [1:0] sz, int rl);
        if (sz == 2'b11) return 1;
        if (wr) return (sz == 2'b00) ? 3 : 2;
        return (sz == 2'b00) ? 3 + 2 * rl : 2 + rl;
    endfunction

    // Load result from the reference byte array.
    function automatic logic [15:0] model_rdata(int inst, logic wr, logic [1:0] sz, logic [15:0] a);
        logic [7:0]  b0, b1;
        logic [15:0] a1;
        a1 = a + 16'd1;
        b0 = ref_mem[inst][a];
        b1 = ref_mem[inst][a1];
        if (wr) return 16'h0;
        case (sz)
            2'b00:   return {b1, b0};
            2'b01:   return {8'h00, b0};
            2'b10:   return {{8{b0[7]}}, b0};
            default: return 16'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        ref_mem[0][a] = d;
        ref_mem[1][a] = d;
        pl_addr = a;
        pl_data = d;
        pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // One complete request with latency, strobe, response and memory checks.
    task automatic do_req(input int inst, input logic wr, input logic [1:0] sz,
                          input logic [15:0] a, input logic [15:0] wd,
                          input logic [15:0] exp_rd, input logic exp_err, input string tag);
        int          rl, exp_l, nacc, lat, obs_n;
        int          obs_off [4];
        logic [1:0]  obs_dir [4];
        logic [15:0] obs_a [4];
        logic [7:0]  obs_d [4];
        logic        busy_ok;
        logic [15:0] got_rd, ea, a1;
        logic        got_err;
        rl = rl_of(inst);
        exp_l = model_lat(wr, sz, rl);
        nacc = (sz == 2'b11) ? 0 : ((sz == 2'b00) ? 2 : 1);
        lat = 0; obs_n = 0; busy_ok = 1'b1; got_rd = 16'h0; got_err = 1'b0;
        @(posedge clk); #1;
        req_valid[inst] = 1'b1; req_write[inst] = wr; req_size[inst] = sz;
        req_addr[inst] = a; req_wdata[inst] = wd;
        @(posedge clk); #1;
        req_valid[inst] = 1'b0; req_write[inst] = ~wr; req_size[inst] = sz ^ 2'b01;
        req_addr[inst] = ~a; req_wdata[inst] = ~wd;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clk);
            if (!busy[inst] || req_ready[inst]) busy_ok = 1'b0;
            if (mem_rd_en[inst] || mem_wr_en[inst]) begin
                if (obs_n < 4) begin
                    obs_off[obs_n] = n;
                    obs_dir[obs_n] = {mem_wr_en[inst], mem_rd_en[inst]};
                    obs_a[obs_n]   = mem_addr[inst];
                    obs_d[obs_n]   = mem_wdata[inst];
                end
                obs_n++;
            end
            if (resp_valid[inst]) begin
                lat = n;
                got_rd = resp_rdata[inst];
                got_err = resp_err[inst];
            end
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_l));
        check({tag, ".rdata"}, {16'h0, got_rd}, {16'h0, exp_rd});
        check({tag, ".err"}, {31'h0, got_err}, {31'h0, exp_err});
        check({tag, ".busy_window"}, {31'h0, busy_ok}, 32'h1);
        @(negedge clk);
        check({tag, ".idle_after"}, {29'h0, req_ready[inst], busy[inst], resp_valid[inst]}, 32'h4);
        check({tag, ".strobe_count"}, 32'(obs_n), 32'(nacc));
        for (int k = 0; k < nacc && k < obs_n; k++) begin
            ea = a + 16'(k);
            check($sformatf("%s.s%0d_offset", tag, k), 32'(obs_off[k]),
                  32'(wr ? 1 + k : 1 + k * (rl + 1)));
            check($sformatf("%s.s%0d_dir", tag, k), {30'h0, obs_dir[k]}, {30'h0, wr, ~wr});
            check($sformatf("%s.s%0d_addr", tag, k), {16'h0, obs_a[k]}, {16'h0, ea});
            if (wr) check($sformatf("%s.s%0d_wdata", tag, k), {24'h0, obs_d[k]},
                          {24'h0, (k == 0) ? wd[7:0] : wd[15:8]});
        end
        if (wr) begin
            a1 = a + 16'd1;
            if (sz != 2'b11) ref_mem[inst][a] = wd[7:0];
            if (sz == 2'b00) ref_mem[inst][a1] = wd[15:8];
            check({tag, ".mem_lo"}, {24'h0, dev_mem(inst, a)}, {24'h0, ref_mem[inst][a]});
            check({tag, ".mem_hi"}, {24'h0, dev_mem(inst, a1)}, {24'h0, ref_mem[inst][a1]});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, got no summary, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int          cnt;
        logic [1:0]  sz;
        logic [15:0] a, wd;
        int          inst, r;
        logic        wr;

        req_valid = '0; req_write = '0; req_size = '0; req_addr = '0; req_wdata = '0;

        vecs[0]  = mk(0, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'h1234, 1'b0, "word_load_rl1");
        vecs[1]  = mk(0, 1'b0, 2'b01, 16'h0020, 16'h0000, 16'h0085, 1'b0, "byte_load_zext");
        vecs[2]  = mk(0, 1'b0, 2'b10, 16'h0020, 16'h0000, 16'hFF85, 1'b0, "byte_load_sext_neg");
        vecs[3]  = mk(0, 1'b0, 2'b10, 16'h0030, 16'h0000, 16'h007F, 1'b0, "byte_load_sext_pos");
        vecs[4]  = mk(0, 1'b1, 2'b00, 16'hFFFF, 16'hBEEF, 16'h0000, 1'b0, "word_store_wrap");
        vecs[5]  = mk(0, 1'b0, 2'b11, 16'h1234, 16'h0000, 16'h0000, 1'b1, "illegal_load");
        vecs[6]  = mk(1, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'h1234, 1'b0, "word_load_rl3");
        vecs[7]  = mk(1, 1'b0, 2'b10, 16'h0020, 16'h0000, 16'hFF85, 1'b0, "byte_load_sext_rl3");
        vecs[8]  = mk(1, 1'b1, 2'b01, 16'h0040, 16'hA5C3, 16'h0000, 1'b0, "byte_store_rl3");
        vecs[9]  = mk(1, 1'b0, 2'b00, 16'h0040, 16'h0000, 16'h66C3, 1'b0, "word_load_after_bstore");
        vecs[10] = mk(0, 1'b0, 2'b00, 16'hFFFF, 16'h0000, 16'hBEEF, 1'b0, "word_load_wrap");
        vecs[11] = mk(1, 1'b1, 2'b11, 16'h0050, 16'h1111, 16'h0000, 1'b1, "illegal_store");

        // Reset state while rst_n is held low.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset%0d.flags", i),
                  {26'h0, req_ready[i], busy[i], resp_valid[i], resp_err[i], mem_wr_en[i], mem_rd_en[i]},
                  32'h20);
            check($sformatf("reset%0d.data", i), {resp_rdata[i], mem_addr[i]}, 32'h0);
            check($sformatf("reset%0d.wdata", i), {24'h0, mem_wdata[i]}, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 128; i++) preload(16'(i), 8'($urandom));
        for (int i = 16'hFFC0; i <= 16'hFFFF; i++) preload(16'(i), 8'($urandom));
        preload(16'h0010, 8'h34);
        preload(16'h0011, 8'h12);
        preload(16'h0020, 8'h85);
        preload(16'h0030, 8'h7F);
        preload(16'h0041, 8'h66);

        for (int v = 0; v < 12; v++)
            do_req(vecs[v].inst, vecs[v].wr, vecs[v].sz, vecs[v].addr, vecs[v].wdata,
                   vecs[v].exp_rd, vecs[v].exp_err, vecs[v].name);

        // req_valid held high: accepted only from IDLE, one illegal response every 2 cycles.
        @(posedge clk); #1;
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_size[1] = 2'b11; req_addr[1] = 16'h0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid[1]) cnt++;
        end
        req_valid[1] = 1'b0;
        check("held_valid.resp_count", 32'(cnt), 32'd4);
        repeat (3) @(posedge clk);

        // Reset during the first WAIT of a word load.
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_size[0] = 2'b00; req_addr[0] = 16'h0010;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("rst_wait.rd_strobe_first", {31'h0, mem_rd_en[0]}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_wait.strobes", {28'h0, mem_wr_en, mem_rd_en}, 32'h0);
        check("rst_wait.flags", {26'h0, req_ready, busy, resp_valid}, 32'h30);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid[0]) cnt++;
        end
        check("rst_wait.no_resp", 32'(cnt), 32'd0);
        check("rst_wait.ready", {31'h0, req_ready[0]}, 32'h1);
        do_req(0, 1'b0, 2'b00, 16'h0010, 16'h0, 16'h1234, 1'b0, "after_reset_load");

        // Reset while a store strobe is high: the strobe must drop at once.
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_size[0] = 2'b00;
        req_addr[0] = 16'h0070; req_wdata[0] = 16'h9C3D;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("rst_store.wr_strobe", {31'h0, mem_wr_en[0]}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_store.wr_dropped", {31'h0, mem_wr_en[0]}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_store.mem_untouched", {24'h0, dev_mem(0, 16'h0070)}, {24'h0, ref_mem[0][16'h0070]});

        // Random traffic against the reference model.
        for (int t = 0; t < 40; t++) begin
            inst = $urandom_range(0, 1);
            wr = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            sz = (r == 9) ? 2'b11 : 2'(r % 3);
            a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 126))
                                            : 16'($urandom_range(16'hFFC0, 16'hFFFF));
            wd = 16'($urandom);
            do_req(inst, wr, sz, a, wd, model_rdata(inst, wr, sz, a), (sz == 2'b11),
                   $sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
